// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU / LSU) arbiter in front of a single memory
// port. One transaction in flight; round-robin on ties; a response watchdog
// turns a silent memory into an error response for the owning requester.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clock,
   input  logic                rst_n,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [DATA_W-1:0]   ifu_rdata,
   output logic                ifu_resp_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic                lsu_wen,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wstrb,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_resp_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic                mem_resp_valid,
   output logic                mem_resp_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

   localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

   state_t              state, state_nxt;
   logic                owner;   // 0 = IFU, 1 = LSU
   logic                last;    // owner of the most recent grant
   logic [ADDR_W-1:0]   addr;
   logic                wen;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic [15:0]         tcnt;

   logic                accept;
   logic                owner_ready;
   logic                rsp_valid;
   logic                rsp_err;
   logic [DATA_W-1:0]   rsp_data;

   // Grant: a lone requester wins; on a tie the one that did not win last time.
   assign ifu_req_ready = (state == IDLE) && ifu_req_valid && (!lsu_req_valid || last);
   assign lsu_req_ready = (state == IDLE) && lsu_req_valid && (!ifu_req_valid || !last);
   assign accept        = ifu_req_ready || lsu_req_ready;
   assign owner_ready   = owner ? lsu_resp_ready : ifu_resp_ready;

   assign busy          = (state != IDLE);
   assign mem_req_valid = (state == REQ);
   assign mem_addr      = addr;
   assign mem_wen       = wen;
   assign mem_wdata     = wdata;
   assign mem_wstrb     = wstrb;

   // State register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state, response routing back to the owner, memory response ready.
   always_comb begin
      state_nxt      = state;
      mem_resp_ready = 1'b0;
      rsp_valid      = 1'b0;
      rsp_err        = 1'b0;
      rsp_data       = '0;
      case (state)
         IDLE: begin
            mem_resp_ready = 1'b1;   // swallow stray late responses
            if (accept) state_nxt = REQ;
         end
         REQ: begin
            if (mem_req_ready) state_nxt = RESP;
         end
         RESP: begin
            mem_resp_ready = owner_ready;
            rsp_valid      = mem_resp_valid;
            rsp_data       = mem_resp_valid ? mem_rdata : '0;
            if (mem_resp_valid && owner_ready)     state_nxt = IDLE;
            else if (!mem_resp_valid && tcnt == TLIM) state_nxt = ERR;
         end
         ERR: begin
            mem_resp_ready = 1'b1;
            rsp_valid      = 1'b1;
            rsp_err        = 1'b1;
            if (owner_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      ifu_resp_valid = rsp_valid & ~owner;
      lsu_resp_valid = rsp_valid &  owner;
      ifu_resp_err   = rsp_err   & ~owner;
      lsu_resp_err   = rsp_err   &  owner;
      ifu_rdata      = owner ? '0 : rsp_data;
      lsu_rdata      = owner ? rsp_data : '0;
   end

   // Capture the granted request; IFU requests are always plain reads.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         owner <= 1'b0;
         last  <= 1'b0;
         addr  <= '0;
         wen   <= 1'b0;
         wdata <= '0;
         wstrb <= '0;
      end else if (accept) begin
         owner <= lsu_req_ready;
         last  <= lsu_req_ready;
         addr  <= lsu_req_ready ? lsu_addr : ifu_addr;
         wen   <= lsu_req_ready & lsu_wen;
         wdata <= lsu_req_ready ? lsu_wdata : '0;
         wstrb <= lsu_req_ready ? lsu_wstrb : '0;
      end
   end

   // Watchdog: counts silent RESP cycles; a stalled valid response is not silent.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         tcnt <= '0;
      else if (state == REQ && mem_req_ready)
         tcnt <= '0;
      else if (state == RESP && !mem_resp_valid && tcnt != TLIM)
         tcnt <= tcnt + 16'd1;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table of transactions, hand-written reset
// and stray-response sequences, then random transactions checked against a
// transaction-level model (round-robin owner, captured fields, timeout rule).
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clock, rst_n;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wstrb;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clock(clock), .rst_n(rst_n),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
      .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
      .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        iv, lv;
      logic [31:0] ia, la;
      logic        lwen;
      logic [31:0] lwd;
      logic [3:0]  lws;
      int          req_dly, resp_dly, bp;
      logic [31:0] rdata;
      logic        exp_lsu, exp_err;
      logic [31:0] exp_addr;
      logic        exp_wen;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wstrb;
   } txn_t;

   int   n_cmp = 0;
   int   n_err = 0;
   logic last_m = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".mem_req_valid"}, mem_req_valid, 0);
      chk({tag, ".mem_addr"}, mem_addr, 0);
      chk({tag, ".mem_wdata"}, mem_wdata, 0);
      chk({tag, ".mem_wstrb"}, mem_wstrb, 0);
      chk({tag, ".mem_wen"}, mem_wen, 0);
      chk({tag, ".resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, 0);
      chk({tag, ".resp_err"}, {ifu_resp_err, lsu_resp_err}, 0);
   endtask

   // Reference: owner by round-robin rule, fields from the winner, error iff
   // memory stays silent for TIMEOUT cycles.
   function automatic txn_t model(input txn_t t);
      txn_t r = t;
      r.exp_lsu   = (t.iv && t.lv) ? !last_m : t.lv;
      r.exp_addr  = r.exp_lsu ? t.la : t.ia;
      r.exp_wen   = r.exp_lsu ? t.lwen : 1'b0;
      r.exp_wdata = r.exp_lsu ? t.lwd : 32'h0;
      r.exp_wstrb = r.exp_lsu ? t.lws : 4'h0;
      r.exp_err   = (t.resp_dly >= TO);
      return r;
   endfunction

   task automatic run_txn(input txn_t t);
      int silent;
      logic o_v, o_e, n_v;
      logic [31:0] o_d;
      ifu_req_valid = t.iv; lsu_req_valid = t.lv;
      ifu_addr = t.ia; lsu_addr = t.la; lsu_wen = t.lwen; lsu_wdata = t.lwd; lsu_wstrb = t.lws;
      ifu_resp_ready = t.exp_lsu;   // owner starts not ready, non-owner ready
      lsu_resp_ready = !t.exp_lsu;
      #1;
      chk("ifu_req_ready", ifu_req_ready, !t.exp_lsu);
      chk("lsu_req_ready", lsu_req_ready, t.exp_lsu);
      chk("req_ready_excl", ifu_req_ready & lsu_req_ready, 0);
      step();
      ifu_req_valid = 0; lsu_req_valid = 0;
      ifu_addr = ~t.ia; lsu_addr = ~t.la; lsu_wdata = ~t.lwd; lsu_wstrb = ~t.lws; lsu_wen = ~t.lwen;
      #1;
      chk("req.mem_req_valid", mem_req_valid, 1);
      chk("req.busy", busy, 1);
      chk("req.mem_addr", mem_addr, t.exp_addr);
      chk("req.mem_wen", mem_wen, t.exp_wen);
      chk("req.mem_wdata", mem_wdata, t.exp_wdata);
      chk("req.mem_wstrb", mem_wstrb, t.exp_wstrb);
      for (int i = 0; i < t.req_dly; i++) begin
         step();
         chk("hold.mem_req_valid", mem_req_valid, 1);
         chk("hold.fields", {mem_addr, mem_wdata}, {t.exp_addr, t.exp_wdata});
         chk("hold.wen_wstrb", {mem_wen, mem_wstrb}, {t.exp_wen, t.exp_wstrb});
      end
      mem_req_ready = 1;
      step();
      mem_req_ready = 0;
      silent = t.exp_err ? TO : t.resp_dly;
      for (int i = 0; i < silent; i++) begin
         mem_resp_valid = 0;
         #1;
         o_v = t.exp_lsu ? lsu_resp_valid : ifu_resp_valid;
         chk("silent.resp_valid", o_v, 0);
         chk("silent.busy", busy, 1);
         step();
      end
      if (t.exp_err) begin
         for (int i = 0; i <= t.bp; i++) begin
            if (i == t.bp) begin
               if (t.exp_lsu) lsu_resp_ready = 1; else ifu_resp_ready = 1;
            end
            #1;
            o_v = t.exp_lsu ? lsu_resp_valid : ifu_resp_valid;
            o_e = t.exp_lsu ? lsu_resp_err : ifu_resp_err;
            o_d = t.exp_lsu ? lsu_rdata : ifu_rdata;
            n_v = t.exp_lsu ? ifu_resp_valid : lsu_resp_valid;
            chk("err.resp_valid", o_v, 1);
            chk("err.resp_err", o_e, 1);
            chk("err.rdata", o_d, 0);
            chk("err.other_valid", n_v, 0);
            chk("err.mem_resp_ready", mem_resp_ready, 1);
            step();
         end
      end else begin
         mem_resp_valid = 1; mem_rdata = t.rdata;
         for (int i = 0; i <= t.bp; i++) begin
            if (i == t.bp) begin
               if (t.exp_lsu) lsu_resp_ready = 1; else ifu_resp_ready = 1;
            end
            #1;
            o_v = t.exp_lsu ? lsu_resp_valid : ifu_resp_valid;
            o_e = t.exp_lsu ? lsu_resp_err : ifu_resp_err;
            o_d = t.exp_lsu ? lsu_rdata : ifu_rdata;
            n_v = t.exp_lsu ? ifu_resp_valid : lsu_resp_valid;
            chk("rsp.resp_valid", o_v, 1);
            chk("rsp.resp_err", o_e, 0);
            chk("rsp.rdata", o_d, t.rdata);
            chk("rsp.other_valid", n_v, 0);
            chk("rsp.mem_resp_ready", mem_resp_ready, (i == t.bp));
            step();
         end
      end
      mem_resp_valid = 0; mem_rdata = 32'hA5A5_5A5A;
      ifu_resp_ready = 0; lsu_resp_ready = 0;
      #1;
      chk("done.busy", busy, 0);
      chk("done.resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
      chk("done.rdata_zero", {ifu_rdata, lsu_rdata}, 0);
      last_m = t.exp_lsu;
   endtask

   txn_t tbl[9];
   txn_t t;

   initial begin
      // iv lv ia la lwen lwd lws req resp bp rdata | lsu err addr wen wdata wstrb
      tbl[0] = '{1,0,32'h8000_0000,32'h0,1,32'hA5A5_A5A5,4'hF,0,1,0,32'hDEAD_BEEF, 0,0,32'h8000_0000,0,32'h0,4'h0};
      tbl[1] = '{1,1,32'h8000_0010,32'h8000_2000,0,32'h0,4'h0,0,0,0,32'h1111_1111, 1,0,32'h8000_2000,0,32'h0,4'h0};
      tbl[2] = '{1,1,32'h8000_0014,32'h8000_2004,1,32'hCAFE_F00D,4'hF,1,2,1,32'h2222_2222, 0,0,32'h8000_0014,0,32'h0,4'h0};
      tbl[3] = '{1,1,32'h8000_0018,32'h8000_2008,1,32'h0BAD_C0DE,4'hC,0,1,0,32'h0, 1,0,32'h8000_2008,1,32'h0BAD_C0DE,4'hC};
      tbl[4] = '{0,1,32'h0,32'h8000_1000,1,32'h1234_5678,4'h3,5,0,0,32'h0, 1,0,32'h8000_1000,1,32'h1234_5678,4'h3};
      tbl[5] = '{1,0,32'h8000_0020,32'h0,0,32'h0,4'h0,0,TO-1,2,32'h3333_3333, 0,0,32'h8000_0020,0,32'h0,4'h0};
      tbl[6] = '{0,1,32'h0,32'h8000_3000,0,32'h55,4'h1,0,9,0,32'h0, 1,1,32'h8000_3000,0,32'h55,4'h1};
      tbl[7] = '{1,0,32'h8000_0024,32'h0,0,32'h0,4'h0,0,TO,1,32'h0, 0,1,32'h8000_0024,0,32'h0,4'h0};
      tbl[8] = '{1,0,32'h8000_0028,32'h0,0,32'h0,4'h0,0,0,300,32'h4444_4444, 0,0,32'h8000_0028,0,32'h0,4'h0};

      rst_n = 0;
      ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_resp_ready = 0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
      #12;
      chk_reset_outputs("reset");
      @(posedge clock); #1;
      rst_n = 1;
      last_m = 0;
      #1;
      chk("idle.mem_resp_ready", mem_resp_ready, 1);

      foreach (tbl[i]) run_txn(tbl[i]);

      // Late memory response while IDLE: consumed, nothing forwarded.
      mem_resp_valid = 1; mem_rdata = 32'hFEED_0001;
      #1;
      chk("stray.mem_resp_ready", mem_resp_ready, 1);
      chk("stray.resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
      chk("stray.rdata", {ifu_rdata, lsu_rdata}, 0);
      step();
      mem_resp_valid = 0;
      #1;
      chk("stray.busy", busy, 0);

      // Make the LSU the last winner, then abort its request in REQ by reset.
      t = '{0,1,32'h0,32'h8000_5000,0,32'h0,4'h0,0,0,0,32'h77, 1,0,32'h8000_5000,0,32'h0,4'h0};
      run_txn(t);
      lsu_req_valid = 1; lsu_addr = 32'h8000_4000; lsu_wen = 1; lsu_wdata = 32'h9999_0000; lsu_wstrb = 4'hF;
      step();
      lsu_req_valid = 0;
      #1;
      chk("abort.in_req", mem_req_valid, 1);
      #2 rst_n = 0;
      #1;
      chk_reset_outputs("abort");
      @(posedge clock); #1;
      rst_n = 1;
      last_m = 0;
      t = '{1,1,32'h8000_0100,32'h8000_0200,0,32'h0,4'h0,0,0,0,32'h88, 0,0,0,0,0,0};
      run_txn(model(t));

      // Random traffic against the transaction-level model.
      for (int n = 0; n < 60; n++) begin
         int r;
         r = $urandom_range(1, 3);
         t.iv = r[0]; t.lv = r[1];
         t.ia = $urandom; t.la = $urandom; t.lwen = $urandom_range(0, 1);
         t.lwd = $urandom; t.lws = 4'($urandom_range(0, 15));
         t.req_dly = $urandom_range(0, 3);
         t.resp_dly = $urandom_range(0, 6);
         t.bp = $urandom_range(0, 3);
         t.rdata = $urandom;
         run_txn(model(t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end

endmodule
